hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3, SHALL set the number of tracked post-decode stages (stage 1 = EX, 2 = MEM, 3 = WB); legal 2..6.
REQ-002 Parameter NPORTS, default 2, SHALL set the number of register read ports checked per issued instruction; legal 1..4.
REQ-003 Parameter ZERO_REG, default 31, SHALL name the hard-zero register (XZR); it is never a hazard source.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 issue_valid  input  1  decode-stage instruction present.
REQ-007 issue_rd  input  5  destination register of the decode instruction.
REQ-008 issue_regwrite / issue_isload / issue_flagwrite / issue_flagread  input  1 each  decode instruction writes Rd / is LDUR / sets flags / is B.cond.
REQ-009 src_addr  input  NPORTS x 5  source register per port.
REQ-010 src_used  input  NPORTS  port actually consumed by the instruction.
REQ-011 flush  input  1  branch taken; discards the decode instruction.
REQ-012 fwd_sel  output  NPORTS x $clog2(DEPTH+1)  0 = register file, k = forward from stage k.
REQ-013 stall  output  1  hold PC and IF/ID; insert bubble.
REQ-014 stage_valid  output  DEPTH  occupancy of each tracked stage.

Function
REQ-015 Each stage entry SHALL hold {valid, rd, regwrite, isload, flagwrite}.
REQ-016 On each clock edge, stage k+1 SHALL load stage k for k = 1..DEPTH-1; the entry leaving stage DEPTH is discarded.
REQ-017 Stage 1 SHALL load the decode instruction when issue_valid && !stall && !flush, otherwise a bubble (valid = 0).
REQ-018 For port p, fwd_sel[p] SHALL be the smallest k with stage k valid, regwrite, rd == src_addr[p]; 0 if none, if !src_used[p], or if src_addr[p] == ZERO_REG.
REQ-019 Youngest match SHALL win when several stages hold the same rd.
REQ-020 stall SHALL assert combinationally when issue_valid and any used port's youngest match is stage 1 with isload = 1 (load-use, one bubble).
REQ-021 stall SHALL also assert when issue_valid && issue_flagread and stage 1 holds a valid flagwrite entry.
REQ-022 flush SHALL force stall = 0 in the same cycle (the discarded instruction never stalls).
REQ-023 While stall is high, fwd_sel values are don't-care; the next cycle re-evaluates against the advanced stages.
REQ-024 A load in stage 2 or later SHALL forward without stall.
REQ-025 Instructions with issue_regwrite = 0 or rd == ZERO_REG SHALL enter stage 1 with regwrite = 0.

Reset
REQ-026 reset low SHALL immediately clear every stage valid bit; stage_valid = 0, fwd_sel = 0, stall = 0 while reset is low.
REQ-027 Reset asserted mid-operation SHALL drop all in-flight entries; no forwarding from pre-reset entries after release.
REQ-028 First rising edge after reset release SHALL behave as a normal issue cycle.

Configuration
REQ-029 With macro HAZARD_PERF_EN defined, outputs stall_cnt (32) and flush_cnt (32) SHALL count cycles with stall = 1 and flush = 1, saturating at all-ones, cleared by reset.
REQ-030 Without HAZARD_PERF_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-031 Package pipe_pkg SHALL hold the stage-entry struct typedef, REG_W = 5, XZR = 31 and the fwd_sel width function.
REQ-032 One sub-module, hazard_match, SHALL perform the per-port youngest-match priority search; instantiated NPORTS times.

Verification
REQ-033 ADD X1 issued, then ADD X2,X1,X3 next cycle -> fwd_sel[0] = 1, stall = 0.
REQ-034 LDUR X4 issued, then ADD X5,X4,X4 -> stall = 1 for one cycle, then fwd_sel[0] = fwd_sel[1] = 2.
REQ-035 ADD X1, ADD X1, then SUB X6,X1,X7 -> fwd_sel[0] = 1 (youngest), not 2.
REQ-036 SUBS issued, then B.cond -> stall = 1 one cycle; same with flush = 1 -> stall = 0, stage 1 bubble.
REQ-037 Writer to X31 followed by reader of X31 -> fwd_sel = 0, stall = 0.
REQ-038 Three writers in flight, reset pulsed low mid-cycle -> stage_valid = 0 immediately; reader of same rd after release -> fwd_sel = 0; with HAZARD_PERF_EN, counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-stage entry type and widths for the hazard scoreboard
package pipe_pkg;
  localparam int REG_W = 5;
  localparam int XZR = 31;
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             isload;
    logic             flagwrite;
  } stage_t;
  function automatic int fwd_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/hazard_match.sv
// hazard_match: youngest-writer search for one read port (0 = register file, k = stage k)
module hazard_match
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int ZERO_REG = XZR,
  parameter int FW = 2
) (
  input  logic [DEPTH-1:0]            wr_valid,
  input  logic [DEPTH-1:0][REG_W-1:0] wr_rd,
  input  logic [REG_W-1:0]            src,
  input  logic                        used,
  output logic [FW-1:0]               sel
);
  always_comb begin
    sel = '0;
    for (int k = DEPTH; k >= 1; k--)
      if (used && src != REG_W'(ZERO_REG) && wr_valid[k-1] && wr_rd[k-1] == src) sel = FW'(k);
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight writers, selects forwarding sources, detects load-use/flag stalls.
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int NPORTS = 2,
  parameter int ZERO_REG = XZR
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                issue_valid,
  input  logic [REG_W-1:0]                    issue_rd,
  input  logic                                issue_regwrite,
  input  logic                                issue_isload,
  input  logic                                issue_flagwrite,
  input  logic                                issue_flagread,
  input  logic [NPORTS-1:0][REG_W-1:0]        src_addr,
  input  logic [NPORTS-1:0]                   src_used,
  input  logic                                flush,
  output logic [NPORTS-1:0][fwd_w(DEPTH)-1:0] fwd_sel,
  output logic                                stall,
  output logic [DEPTH-1:0]                    stage_valid
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                         stall_cnt,
  output logic [31:0]                         flush_cnt
`endif
);
  localparam int FW = fwd_w(DEPTH);
  stage_t [DEPTH-1:0] stg;
  stage_t nxt;
  logic [DEPTH-1:0] wr_valid;
  logic [DEPTH-1:0][REG_W-1:0] wr_rd;
  logic [NPORTS-1:0] load_use;
  logic unused_tail;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_valid[i] = stg[i].valid;
      wr_valid[i] = stg[i].valid && stg[i].regwrite;
      wr_rd[i] = stg[i].rd;
    end
  end
  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    hazard_match #(.DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .FW(FW)) u_match (
      .wr_valid(wr_valid),
      .wr_rd(wr_rd),
      .src(src_addr[p]),
      .used(src_used[p]),
      .sel(fwd_sel[p])
    );
    assign load_use[p] = fwd_sel[p] == FW'(1) && stg[0].isload;
  end
  assign stall = issue_valid && !flush &&
                 (|load_use || (issue_flagread && stg[0].valid && stg[0].flagwrite));
  // regwrite is cleared on entry for XZR so the matcher never sees it as a producer
  assign nxt = '{valid: issue_valid && !stall && !flush, rd: issue_rd,
                 regwrite: issue_regwrite && issue_rd != REG_W'(ZERO_REG),
                 isload: issue_isload, flagwrite: issue_flagwrite};
  // the oldest entry's load/flag bits are only carried for uniformity of the shift
  assign unused_tail = stg[DEPTH-1].isload ^ stg[DEPTH-1].flagwrite;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stg <= '0;
    else stg <= {stg[DEPTH-2:0], nxt};
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, stall && stall_cnt != '1};
      flush_cnt <= flush_cnt + {31'd0, flush && flush_cnt != '1};
    end
  end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of forwarding, stalls, flush and reset on the default configuration
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic issue_valid = 1'b0;
  logic [4:0] issue_rd = '0;
  logic issue_regwrite = 1'b0, issue_isload = 1'b0, issue_flagwrite = 1'b0, issue_flagread = 1'b0;
  logic [1:0][4:0] src_addr = '0;
  logic [1:0] src_used = '0;
  logic flush = 1'b0;
  logic [1:0][1:0] fwd_sel;
  logic stall;
  logic [2:0] stage_valid;
  int errors = 0;
  int checks = 0;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regwrite(issue_regwrite), .issue_isload(issue_isload),
    .issue_flagwrite(issue_flagwrite), .issue_flagread(issue_flagread),
    .src_addr(src_addr), .src_used(src_used), .flush(flush),
    .fwd_sel(fwd_sel), .stall(stall), .stage_valid(stage_valid)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                       input logic fw, input logic fr, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] u, input logic fl);
    issue_valid = v; issue_rd = rd; issue_regwrite = rw; issue_isload = ld;
    issue_flagwrite = fw; issue_flagread = fr;
    src_addr[0] = s0; src_addr[1] = s1; src_used = u; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    drive(1, 5'd1, 1, 1, 1, 1, 5'd1, 5'd1, 2'b11, 0);
    chk("rst_stage_valid", 32'(stage_valid), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fwd", 32'(fwd_sel), 0);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    tick();
    chk("idle_stage_valid", 32'(stage_valid), 0);
    // ADD X1 ; ADD X2,X1,X3
    drive(1, 5'd1, 1, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("add1_stall", 32'(stall), 0);
    tick();
    drive(1, 5'd2, 1, 0, 0, 0, 5'd1, 5'd3, 2'b11, 0);
    chk("raw_fwd0", 32'(fwd_sel[0]), 1);
    chk("raw_fwd1", 32'(fwd_sel[1]), 0);
    chk("raw_stall", 32'(stall), 0);
    tick();
    chk("two_in_flight", 32'(stage_valid), 3'b011);
    // LDUR X4 ; ADD X5,X4,X4
    drive(1, 5'd4, 1, 1, 0, 0, 0, 0, 2'b00, 0);
    tick();
    chk("full_pipe", 32'(stage_valid), 3'b111);
    drive(0, 5'd5, 1, 0, 0, 0, 5'd4, 5'd4, 2'b11, 0);
    chk("lu_novalid_stall", 32'(stall), 0);
    drive(1, 5'd5, 1, 0, 0, 0, 5'd4, 5'd4, 2'b11, 0);
    chk("lu_stall", 32'(stall), 1);
    tick();
    chk("lu_bubble", 32'(stage_valid), 3'b110);
    chk("lu_stall_released", 32'(stall), 0);
    chk("lu_fwd0", 32'(fwd_sel[0]), 2);
    chk("lu_fwd1", 32'(fwd_sel[1]), 2);
    tick();
    // ADD X1 ; ADD X1 ; SUB X6,X1,X5 (X5 now in stage 3)
    drive(1, 5'd1, 1, 0, 0, 0, 0, 0, 2'b00, 0);
    tick();
    tick();
    drive(1, 5'd6, 1, 0, 0, 0, 5'd1, 5'd5, 2'b11, 0);
    chk("youngest_fwd0", 32'(fwd_sel[0]), 1);
    chk("stage3_fwd1", 32'(fwd_sel[1]), 3);
    chk("youngest_stall", 32'(stall), 0);
    tick();
    // SUBS X9 ; B.cond
    drive(1, 5'd9, 1, 0, 1, 0, 0, 0, 2'b00, 0);
    tick();
    drive(1, 5'd0, 0, 0, 0, 1, 0, 0, 2'b00, 0);
    chk("flag_stall", 32'(stall), 1);
    drive(1, 5'd0, 0, 0, 0, 1, 0, 0, 2'b00, 1);
    chk("flag_flush_stall", 32'(stall), 0);
    tick();
    chk("flush_bubble", 32'(stage_valid), 3'b110);
    drive(1, 5'd10, 0, 0, 0, 0, 5'd9, 5'd9, 2'b10, 0);
    chk("unused_port_fwd0", 32'(fwd_sel[0]), 0);
    chk("used_port_fwd1", 32'(fwd_sel[1]), 2);
    tick();
    // X31 writer (a load) then X31 reader; non-writing X12 then reader of X12
    drive(1, 5'd31, 1, 1, 0, 0, 0, 0, 2'b00, 0);
    tick();
    drive(1, 5'd12, 0, 0, 0, 0, 5'd31, 5'd31, 2'b11, 0);
    chk("xzr_fwd", 32'(fwd_sel), 0);
    chk("xzr_stall", 32'(stall), 0);
    tick();
    drive(1, 5'd13, 1, 0, 0, 0, 5'd12, 5'd31, 2'b11, 0);
    chk("noregwrite_fwd", 32'(fwd_sel), 0);
    tick();
    // three writers of X3 then asynchronous reset mid-cycle
    drive(1, 5'd3, 1, 0, 0, 0, 0, 0, 2'b00, 0);
    tick();
    tick();
    tick();
    drive(1, 5'd14, 1, 0, 0, 0, 5'd3, 5'd3, 2'b11, 0);
    chk("pre_reset_fwd0", 32'(fwd_sel[0]), 1);
    chk("pre_reset_valid", 32'(stage_valid), 3'b111);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(stage_valid), 0);
    chk("async_rst_fwd", 32'(fwd_sel), 0);
    chk("async_rst_stall", 32'(stall), 0);
`ifdef HAZARD_PERF_EN
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_fwd", 32'(fwd_sel), 0);
    tick();
    chk("post_rst_issue", 32'(stage_valid), 3'b001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
